avalon_arbiter_2m: RTL and testbench

//  Shares one Avalon-MM slave (avl_slave_mem / avl_slave_mem_slow) between two Avalon masters:
//  m0 = mips_cpu_bus, m1 = secondary master (memory loader / debug port). Grants whole

---
 rtl/avalon_arbiter_2m.sv | 126 ++++++++++++
 tb/tb_avalon_arbiter_2m.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/avalon_arbiter_2m.sv
// rtl/avalon_arbiter_2m.sv - two-master Avalon-MM arbiter granting whole transactions to one slave
// Optional round-robin tie-break enabled by defining AVALON_ARB_ROUND_ROBIN_EN.
module avalon_arbiter_2m #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest,
  output logic [1:0]          grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   req0;
  logic   req1;
  logic   tie_to_m1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef AVALON_ARB_ROUND_ROBIN_EN
  // 1 = m1 owned the slave most recently; ties go to the other master.
  logic last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && next_state != IDLE) begin
      last_grant <= (next_state == GNT1);
    end
  end

  assign tie_to_m1 = ~last_grant;
`else
  assign tie_to_m1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= 2'b00;
    end else begin
      state <= next_state;
      grant <= {next_state == GNT1, next_state == GNT0};
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          next_state = tie_to_m1 ? GNT1 : GNT0;
        end else if (req0) begin
          next_state = GNT0;
        end else if (req1) begin
          next_state = GNT1;
        end
      end
      // Leave on completion or when the owner abandons its request.
      GNT0: if (!(req0 && s_waitrequest)) next_state = IDLE;
      GNT1: if (!(req1 && s_waitrequest)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state)
      GNT0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      GNT1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_avalon_arbiter_2m.sv
// tb/tb_avalon_arbiter_2m.sv - self-checking bench for avalon_arbiter_2m
// Round-robin expectations follow AVALON_ARB_ROUND_ROBIN_EN when defined.
module tb_avalon_arbiter_2m;

  localparam logic [31:0] A0  = 32'hBFC0_0000;
  localparam logic [31:0] A1  = 32'h0000_1000;
  localparam logic [31:0] D0  = 32'h1111_2222;
  localparam logic [31:0] D1  = 32'hDEAD_BEEF;
  localparam logic [3:0]  BE0 = 4'b1111;
  localparam logic [3:0]  BE1 = 4'b0011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_address = A0, m1_address = A1;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = D0, m1_writedata = D1;
  logic [3:0]  m0_byteenable = BE0, m1_byteenable = BE1;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] s_address, s_writedata;
  logic        s_read, s_write;
  logic [3:0]  s_byteenable;
  logic [31:0] s_readdata = 32'h0;
  logic        s_waitrequest = 1'b1;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  avalon_arbiter_2m #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant)
  );

  always #5 clk = ~clk;

  // sel: 0 = slave driven by m0, 1 = by m1, 2 = idle (all zero)
  typedef struct {
    logic       r0, w0, r1, w1, sw;
    logic [1:0] grant;
    logic       wq0, wq1;
    int         sel;
  } row_t;

  row_t tbl[20];
  row_t sb[$];
  logic [1:0] gexp[$];

  function automatic row_t mk(logic r0, logic w0, logic r1, logic w1, logic sw,
                              logic [1:0] g, logic wq0, logic wq1, int sel);
    row_t r;
    r.r0 = r0; r.w0 = w0; r.r1 = r1; r.w1 = w1; r.sw = sw;
    r.grant = g; r.wq0 = wq0; r.wq1 = wq1; r.sel = sel;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_row(row_t r);
    logic        er, ew;
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    er = (r.sel == 0) ? r.r0 : (r.sel == 1) ? r.r1 : 1'b0;
    ew = (r.sel == 0) ? r.w0 : (r.sel == 1) ? r.w1 : 1'b0;
    ea = (r.sel == 0) ? A0 : (r.sel == 1) ? A1 : 32'h0;
    ed = (r.sel == 0) ? D0 : (r.sel == 1) ? D1 : 32'h0;
    eb = (r.sel == 0) ? BE0 : (r.sel == 1) ? BE1 : 4'h0;
    chk("grant", {30'h0, grant}, {30'h0, r.grant});
    chk("m0_waitrequest", {31'h0, m0_waitrequest}, {31'h0, r.wq0});
    chk("m1_waitrequest", {31'h0, m1_waitrequest}, {31'h0, r.wq1});
    chk("s_read", {31'h0, s_read}, {31'h0, er});
    chk("s_write", {31'h0, s_write}, {31'h0, ew});
    chk("s_address", s_address, ea);
    chk("s_writedata", s_writedata, ed);
    chk("s_byteenable", {28'h0, s_byteenable}, {28'h0, eb});
    chk("m0_readdata", m0_readdata, 32'h3C02_1234 + 32'(cyc));
    chk("m1_readdata", m1_readdata, 32'h3C02_1234 + 32'(cyc));
  endtask

  initial begin
    row_t r;
    int   seen;

    // r0 w0 r1 w1 sw | grant wq0 wq1 sel
    tbl[0]  = mk(1,0,0,0,1, 2'b00,1,1,2);  // m0 read, slave stalls 3 cycles
    tbl[1]  = mk(1,0,0,0,1, 2'b01,1,1,0);
    tbl[2]  = mk(1,0,0,0,1, 2'b01,1,1,0);
    tbl[3]  = mk(1,0,0,0,1, 2'b01,1,1,0);
    tbl[4]  = mk(1,0,0,0,0, 2'b01,0,1,0);
    tbl[5]  = mk(0,0,0,0,0, 2'b00,1,1,2);
    tbl[6]  = mk(0,0,0,1,0, 2'b00,1,1,2);  // m1 write, zero-wait slave
    tbl[7]  = mk(0,0,0,1,0, 2'b10,1,0,1);
    tbl[8]  = mk(0,0,0,0,0, 2'b00,1,1,2);
    tbl[9]  = mk(1,0,1,0,0, 2'b00,1,1,2);  // simultaneous reads
    tbl[10] = mk(1,0,1,0,0, 2'b01,0,1,0);
    tbl[11] = mk(0,0,1,0,0, 2'b00,1,1,2);
    tbl[12] = mk(0,0,1,0,0, 2'b10,1,0,1);
    tbl[13] = mk(0,0,0,0,0, 2'b00,1,1,2);
    tbl[14] = mk(1,0,1,0,1, 2'b00,1,1,2);  // m0 abandons a stalled read
    tbl[15] = mk(1,0,1,0,1, 2'b01,1,1,0);
    tbl[16] = mk(0,0,1,0,1, 2'b01,1,1,0);
    tbl[17] = mk(0,0,1,0,0, 2'b00,1,1,2);
    tbl[18] = mk(0,0,1,0,0, 2'b10,1,0,1);
    tbl[19] = mk(0,0,0,0,0, 2'b00,1,1,2);

    // reset state
    s_readdata = 32'h3C02_1234;
    m0_read = 1'b1;
    #3;
    chk("rst_grant", {30'h0, grant}, 32'h0);
    chk("rst_s_read", {31'h0, s_read}, 32'h0);
    chk("rst_s_address", s_address, 32'h0);
    chk("rst_m0_wait", {31'h0, m0_waitrequest}, 32'h1);
    chk("rst_m1_wait", {31'h0, m1_waitrequest}, 32'h1);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc = i;
      m0_read = tbl[i].r0; m0_write = tbl[i].w0;
      m1_read = tbl[i].r1; m1_write = tbl[i].w1;
      s_waitrequest = tbl[i].sw;
      s_readdata = 32'h3C02_1234 + 32'(i);
      sb.push_back(tbl[i]);
      @(negedge clk);
      r = sb.pop_front();
      check_row(r);
    end

    // both masters request continuously for six transactions
    do_reset();
    for (int i = 0; i < 6; i++) begin
`ifdef AVALON_ARB_ROUND_ROBIN_EN
      gexp.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
`else
      gexp.push_back(2'b01);
`endif
    end
    seen = 0;
    m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
    for (int i = 0; i < 40 && gexp.size() > 0; i++) begin
      @(negedge clk);
      cyc = 100 + i;
      if (grant != 2'b00) begin
        chk("contend_grant", {30'h0, grant}, {30'h0, gexp.pop_front()});
        seen++;
      end
    end
    chk("contend_count", 32'(seen), 32'd6);

    // asynchronous reset in the middle of a stalled m0 read
    do_reset();
    cyc = 200;
    m0_read = 1'b1; s_waitrequest = 1'b1;
    @(posedge clk); #3;
    chk("mid_grant", {30'h0, grant}, 32'h1);
    chk("mid_s_read", {31'h0, s_read}, 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_s_read", {31'h0, s_read}, 32'h0);
    chk("arst_grant", {30'h0, grant}, 32'h0);
    chk("arst_m0_wait", {31'h0, m0_waitrequest}, 32'h1);
    chk("arst_m1_wait", {31'h0, m1_waitrequest}, 32'h1);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    s_waitrequest = 1'b0;
    s_readdata = 32'h3C02_1234;
    @(negedge clk);
    chk("rearb_grant", {30'h0, grant}, 32'h1);
    chk("rearb_m0_wait", {31'h0, m0_waitrequest}, 32'h0);
    chk("rearb_readdata", m0_readdata, 32'h3C02_1234);
    @(posedge clk); #1;
    m0_read = 1'b0;
    @(negedge clk);
    chk("rearb_idle", {30'h0, grant}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
